// File: rtl/scan_ctrl_pkg.sv
// Shared state encoding and widths for the raster-scan sequencer.
package scan_ctrl_pkg;
  localparam int CNT_W  = 4;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/scan_ctrl_counter_4.sv
// 4-bit clear/keep counter: clear wins, keep holds, otherwise +1.
module counter_4
  import scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             keep,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_count <= '0;
    else if (clear)  r_count <= '0;
    else if (!keep)  r_count <= r_count + 1'b1;
  end

  assign count = r_count;
endmodule

// File: rtl/scan_ctrl.sv
// Raster-scan sequencer: walks ROWS x COLS, one address beat per ack.
// All outputs decode from registered state and counter values only.
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              ack,
  output logic              valid,
  output logic [CNT_W-1:0]  row,
  output logic [CNT_W-1:0]  col,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              busy,
  output logic              done
);
  localparam logic [CNT_W-1:0]  COL_END = CNT_W'(COLS - 1);
  localparam logic [CNT_W-1:0]  ROW_END = CNT_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_col_clr, w_col_keep, w_row_clr, w_row_keep;
  logic [CNT_W-1:0] w_row, w_col;
  logic             w_col_end, w_last;

  counter_4 u_col (.clk(clk), .rst(rst), .clear(w_col_clr), .keep(w_col_keep), .count(w_col));
  counter_4 u_row (.clk(clk), .rst(rst), .clear(w_row_clr), .keep(w_row_keep), .count(w_row));

  assign w_col_end = (w_col == COL_END);
  assign w_last    = w_col_end && (w_row == ROW_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_clr   = 1'b0;
    w_col_keep  = 1'b1;
    w_row_clr   = 1'b0;
    w_row_keep  = 1'b1;
    case (r_state)
      IDLE: begin
        w_col_clr = 1'b1;
        w_row_clr = 1'b1;
        if (start) w_state_nxt = SCAN;
      end
      SCAN: begin
        // abort outranks ack: a beat acked alongside abort is dropped
        if (abort) begin
          w_col_clr   = 1'b1;
          w_row_clr   = 1'b1;
          w_state_nxt = IDLE;
        end else if (ack) begin
          if (w_last) begin
            w_col_clr   = 1'b1;
            w_row_clr   = 1'b1;
            w_state_nxt = DONE;
          end else if (w_col_end) begin
            w_col_clr  = 1'b1;
            w_row_keep = 1'b0;
          end else begin
            w_col_keep = 1'b0;
          end
        end
      end
      DONE: begin
        w_col_clr   = 1'b1;
        w_row_clr   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_col_clr   = 1'b1;
        w_row_clr   = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign valid = (r_state == SCAN);
  assign busy  = (r_state == SCAN) || (r_state == DONE);
  assign done  = (r_state == DONE);
  assign last  = valid && w_last;
  assign row   = w_row;
  assign col   = w_col;
  assign addr  = ADDR_W'(w_row) * COLS_A + ADDR_W'(w_col);
endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl across four window geometries sharing clk/rst.
module tb_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [4];
  logic       abort [4];
  logic       ack   [4];
  logic       valid [4];
  logic       last  [4];
  logic       busy  [4];
  logic       done  [4];
  logic [3:0] row   [4];
  logic [3:0] col   [4];
  logic [7:0] addr  [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // 0: 4x3, 1: 16x2, 2: 1x1, 3: 16x16
  scan_ctrl #(.COLS(4),  .ROWS(3))  u_dut0 (.clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .ack(ack[0]),
    .valid(valid[0]), .row(row[0]), .col(col[0]), .addr(addr[0]), .last(last[0]), .busy(busy[0]), .done(done[0]));
  scan_ctrl #(.COLS(16), .ROWS(2))  u_dut1 (.clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .ack(ack[1]),
    .valid(valid[1]), .row(row[1]), .col(col[1]), .addr(addr[1]), .last(last[1]), .busy(busy[1]), .done(done[1]));
  scan_ctrl #(.COLS(1),  .ROWS(1))  u_dut2 (.clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .ack(ack[2]),
    .valid(valid[2]), .row(row[2]), .col(col[2]), .addr(addr[2]), .last(last[2]), .busy(busy[2]), .done(done[2]));
  scan_ctrl #(.COLS(16), .ROWS(16)) u_dut3 (.clk(clk), .rst(rst), .start(start[3]), .abort(abort[3]), .ack(ack[3]),
    .valid(valid[3]), .row(row[3]), .col(col[3]), .addr(addr[3]), .last(last[3]), .busy(busy[3]), .done(done[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input int k);
    chk({tag, "_valid"}, valid[k], 0);
    chk({tag, "_busy"},  busy[k],  0);
    chk({tag, "_done"},  done[k],  0);
    chk({tag, "_last"},  last[k],  0);
    chk({tag, "_row"},   row[k],   0);
    chk({tag, "_col"},   col[k],   0);
    chk({tag, "_addr"},  addr[k],  0);
  endtask

  // Full scan; bp selects ack pattern 1,0,0,1 repeating, else ack held high.
  task automatic run_scan(input int k, input int cols, input int rows, input bit bp, input int exp_busy);
    int beat = 0, cyc = 0, nbusy = 0;
    bit a;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    while (beat < cols * rows && cyc < 2000) begin
      chk("scan_valid", valid[k], 1);
      chk("scan_addr",  addr[k],  beat);
      chk("scan_row",   row[k],   beat / cols);
      chk("scan_col",   col[k],   beat % cols);
      chk("scan_last",  last[k],  beat == cols * rows - 1);
      chk("scan_done",  done[k],  0);
      if (busy[k]) nbusy++;
      a = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      ack[k] = a;
      @(negedge clk);
      if (a) beat++;
      cyc++;
    end
    ack[k] = 1'b0;
    chk("beats_accepted", beat, cols * rows);
    chk("done_pulse",     done[k],  1);
    chk("done_valid",     valid[k], 0);
    if (busy[k]) nbusy++;
    chk("busy_cycles",    nbusy, exp_busy);
    @(negedge clk);
    chk("post_done_busy", busy[k], 0);
    chk("post_done_done", done[k], 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; ack[i] = 1'b0;
    end
    #3;
    for (int i = 0; i < 4; i++) chk_idle("reset", i);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 4x3, ack high: 12 beats + DONE -> 13 busy cycles
    run_scan(0, 4, 3, 1'b0, 13);
    // 4x3, ack 1,0,0,1: 12 accepts over 24 cycles + DONE
    run_scan(0, 4, 3, 1'b1, 25);
    // 16x2 row wrap: addr 16 at row 1 col 0, last at 31
    run_scan(1, 16, 2, 1'b0, 33);

    // abort at the 6th beat with ack also high
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    ack[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_pre_addr", addr[0], 5);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    ack[0] = 1'b0;
    chk_idle("abort", 0);
    @(negedge clk);
    chk("abort_no_done", done[0], 0);
    run_scan(0, 4, 3, 1'b0, 13);

    // 1x1: single beat, start during DONE ignored
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    chk("deg_valid", valid[2], 1);
    chk("deg_addr",  addr[2],  0);
    chk("deg_last",  last[2],  1);
    ack[2] = 1'b1;
    @(negedge clk);
    ack[2] = 1'b0;
    chk("deg_done",  done[2],  1);
    start[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    chk("deg_start_in_done_valid", valid[2], 0);
    chk("deg_start_in_done_busy",  busy[2],  0);
    @(negedge clk);
    chk("deg_still_idle", valid[2], 0);

    // start and abort together in IDLE: start wins
    start[2] = 1'b1;
    abort[2] = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    abort[2] = 1'b0;
    chk("start_vs_abort_valid", valid[2], 1);
    ack[2] = 1'b1;
    @(negedge clk);
    ack[2] = 1'b0;
    chk("start_vs_abort_done", done[2], 1);
    @(negedge clk);

    // async reset mid-scan at row 3 col 5 on 16x16
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    ack[3] = 1'b1;
    repeat (53) @(negedge clk);
    ack[3] = 1'b0;
    chk("pre_rst_row",  row[3],  3);
    chk("pre_rst_col",  col[3],  5);
    chk("pre_rst_addr", addr[3], 53);
    #2 rst = 1'b1;
    #1;
    chk_idle("async_rst", 3);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_no_done", done[3], 0);
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    chk("post_rst_valid", valid[3], 1);
    chk("post_rst_addr",  addr[3],  0);
    abort[3] = 1'b1;
    @(negedge clk);
    abort[3] = 1'b0;
    chk("post_rst_abort_idle", busy[3], 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
